// File: rtl/probe_scheduler_pkg.sv
// rtl/probe_scheduler_pkg.sv - shared types and constants for the probe scheduler
//
// Purpose: FSM state encoding, latency/sum widths and the default
// result timeout used by probe_scheduler and lat_stats.
package probe_sched_pkg;

  localparam int LAT_W           = 32;
  localparam int SUM_W           = 48;
  localparam int TIMEOUT_DEFAULT = 125000;  // 1 ms at 125 MHz

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_TX,
    ST_WAIT_RX,
    ST_GAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/probe_scheduler_lat_stats.sv
// rtl/probe_scheduler_lat_stats.sv - latency min/max/saturating-sum accumulator
//
// Purpose: tracks the smallest, largest and summed latency of a run.
// Ports:
//   clock, reset_n    : clock, synchronous active-low reset
//   clear             : restart statistics (min all-ones, max 0, sum 0)
//   update, latency   : fold one latency sample into the statistics
//   lat_min, lat_max  : unsigned extremes seen since clear
//   lat_sum           : sum of samples, saturating at all-ones
module lat_stats
  import probe_sched_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             update,
  input  logic [LAT_W-1:0] latency,
  output logic [LAT_W-1:0] lat_min,
  output logic [LAT_W-1:0] lat_max,
  output logic [SUM_W-1:0] lat_sum
);

  // One extra bit catches the carry out so the sum can clamp instead of wrap.
  logic [SUM_W:0] sum_ext;
  assign sum_ext = {1'b0, lat_sum} + {{(SUM_W + 1 - LAT_W){1'b0}}, latency};

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      lat_min <= '1;
      lat_max <= '0;
      lat_sum <= '0;
    end else if (update) begin
      if (latency < lat_min) lat_min <= latency;
      if (latency > lat_max) lat_max <= latency;
      lat_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
    end
  end

endmodule

// File: rtl/probe_scheduler.sv
// rtl/probe_scheduler.sv - latency probe sequencer with run counters and statistics
//
// Purpose: issues probe_count probe requests (0 = until stop) separated by
// gap_cycles idle cycles, waits for each latency result or a timeout, and
// keeps sent/received/lost counters plus optional latency statistics.
// Build option: define PROBE_SCHED_STATS_EN to build lat_min/lat_max/lat_sum;
// otherwise those outputs are constant 0.
// Ports:
//   clock, reset_n            : clock, synchronous active-low reset
//   start, stop               : run control pulses
//   probe_count, gap_cycles   : run setup, sampled on an accepted start
//   tx_req / tx_ack / tx_done : probe frame handshake with the sender
//   rx_valid, rx_latency      : latency result from the receiver
//   busy, done                : run in progress / one-cycle end-of-run pulse
//   sent_cnt, recv_cnt, lost_cnt : saturating run counters
//   lat_min, lat_max, lat_sum : latency statistics
module probe_scheduler
  import probe_sched_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int GAP_W   = 24,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] probe_count,
  input  logic [GAP_W-1:0] gap_cycles,
  output logic             tx_req,
  input  logic             tx_ack,
  input  logic             tx_done,
  input  logic             rx_valid,
  input  logic [LAT_W-1:0] rx_latency,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0] recv_cnt,
  output logic [CNT_W-1:0] lost_cnt,
  output logic [LAT_W-1:0] lat_min,
  output logic [LAT_W-1:0] lat_max,
  output logic [SUM_W-1:0] lat_sum
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] count_reg;
  logic [GAP_W-1:0] gap_reg;
  logic [GAP_W-1:0] gap_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             stop_flag;

  logic start_ok, ack_ok, rx_ok, to_expire, run_end, gap_end;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign start_ok  = (state == ST_IDLE) && start;
  assign ack_ok    = (state == ST_ISSUE) && tx_ack;
  assign rx_ok     = (state == ST_WAIT_RX) && rx_valid;
  // A result arriving on the expiry cycle wins over the timeout.
  assign to_expire = (state == ST_WAIT_RX) && !rx_valid && (to_cnt == TO_W'(TIMEOUT - 1));
  // A stop pulse on the deciding cycle itself is honoured as well as an earlier one.
  assign run_end   = stop_flag || stop || ((count_reg != '0) && (sent_cnt == count_reg));
  // A zero gap still spends one cycle in GAP.
  assign gap_end   = (gap_reg == '0) || (gap_cnt == gap_reg - GAP_W'(1));

  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_req     = 1'b0;
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    case (state)
      ST_IDLE:    if (start) state_next = ST_ISSUE;
      ST_ISSUE: begin
        tx_req = 1'b1;
        if (tx_ack) state_next = ST_WAIT_TX;
      end
      ST_WAIT_TX: if (tx_done) state_next = ST_WAIT_RX;
      ST_WAIT_RX: if (rx_ok || to_expire) state_next = run_end ? ST_DONE : ST_GAP;
      ST_GAP:     if (gap_end) state_next = run_end ? ST_DONE : ST_ISSUE;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_reg <= '0;
      gap_reg   <= '0;
      stop_flag <= 1'b0;
      sent_cnt  <= '0;
      recv_cnt  <= '0;
      lost_cnt  <= '0;
    end else if (start_ok) begin
      count_reg <= probe_count;
      gap_reg   <= gap_cycles;
      stop_flag <= 1'b0;
      sent_cnt  <= '0;
      recv_cnt  <= '0;
      lost_cnt  <= '0;
    end else begin
      if (state != ST_IDLE && stop) stop_flag <= 1'b1;
      if (ack_ok)    sent_cnt <= sat_inc(sent_cnt);
      if (rx_ok)     recv_cnt <= sat_inc(recv_cnt);
      if (to_expire) lost_cnt <= sat_inc(lost_cnt);
    end
  end

  // Timeout counter restarts when the frame leaves the sender.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (state == ST_WAIT_TX && tx_done) begin
      to_cnt <= '0;
    end else if (state == ST_WAIT_RX && !to_expire) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || state != ST_GAP) gap_cnt <= '0;
    else                             gap_cnt <= gap_cnt + 1'b1;
  end

`ifdef PROBE_SCHED_STATS_EN
  lat_stats u_lat_stats (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (start_ok),
    .update  (rx_ok),
    .latency (rx_latency),
    .lat_min (lat_min),
    .lat_max (lat_max),
    .lat_sum (lat_sum)
  );
`else
  logic unused_latency;
  assign unused_latency = ^rx_latency;
  assign lat_min = '0;
  assign lat_max = '0;
  assign lat_sum = '0;
`endif

endmodule

// File: tb/tb_probe_scheduler.sv
// tb/tb_probe_scheduler.sv - self-checking bench for probe_scheduler
module tb_probe_scheduler;

  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] probe_count = '0;
  logic [23:0] gap_cycles = '0;
  logic        tx_ack = 1'b0;
  logic        tx_done = 1'b0;
  logic        rx_valid = 1'b0;
  logic [31:0] rx_latency = '0;
  logic        tx_req, busy, done;
  logic [15:0] sent_cnt, recv_cnt, lost_cnt;
  logic [31:0] lat_min, lat_max;
  logic [47:0] lat_sum;

  probe_scheduler #(.CNT_W(16), .GAP_W(24), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
    .probe_count(probe_count), .gap_cycles(gap_cycles),
    .tx_req(tx_req), .tx_ack(tx_ack), .tx_done(tx_done),
    .rx_valid(rx_valid), .rx_latency(rx_latency),
    .busy(busy), .done(done),
    .sent_cnt(sent_cnt), .recv_cnt(recv_cnt), .lost_cnt(lost_cnt),
    .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails = 0;
  int done_seen = 0;

  always @(negedge clock) if (done) done_seen++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          n, gap, ack, rxd;
    logic [3:0][31:0] lat;
    logic [3:0]  drop;
    int          e_sent, e_recv, e_lost;
    logic [31:0] e_min, e_max;
    logic [47:0] e_sum;
  } vec_t;

  vec_t tab[5];

  function automatic logic [47:0] sx(input logic [47:0] v);
`ifdef PROBE_SCHED_STATS_EN
    return v;
`else
    return (v & 48'h0);
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req(input string name, output int n);
    n = 0;
    while (!tx_req && n < 300) begin
      tick();
      n++;
    end
    if (!tx_req) chk({name, " tx_req wait"}, 64'(tx_req), 64'd1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk({name, " done"}, 64'(done), 64'd1);
  endtask

  task automatic do_probe(input int ack, input int rxd, input logic [31:0] lat, input logic drop);
    repeat (ack) tick();
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    repeat (rxd) tick();
    if (!drop) begin
      rx_latency = lat; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    end
  endtask

  task automatic set_vec(input int i, input int n, input int gap, input int ack, input int rxd,
                         input logic [31:0] l0, input logic [31:0] l1,
                         input logic [31:0] l2, input logic [31:0] l3, input logic [3:0] drop,
                         input int es, input int er, input int el,
                         input logic [31:0] emin, input logic [31:0] emax, input logic [47:0] esum);
    tab[i].n = n; tab[i].gap = gap; tab[i].ack = ack; tab[i].rxd = rxd;
    tab[i].lat[0] = l0; tab[i].lat[1] = l1; tab[i].lat[2] = l2; tab[i].lat[3] = l3;
    tab[i].drop = drop;
    tab[i].e_sent = es; tab[i].e_recv = er; tab[i].e_lost = el;
    tab[i].e_min = emin; tab[i].e_max = emax; tab[i].e_sum = esum;
  endtask

  initial begin
    int n, d0, req_seen;
    string s;

    //            n gap ack rxd  lat0          lat1  lat2  lat3 drop   s r l  min           max           sum
    set_vec(0, 3, 10, 2, 3, 32'd100,      32'd200, 32'd150, 32'd0, 4'b0000, 3, 3, 0, 32'd100, 32'd200, 48'd450);
    set_vec(1, 2, 0,  0, 2, 32'd7,        32'd55,  32'd0,   32'd0, 4'b0001, 2, 1, 1, 32'd55,  32'd55,  48'd55);
    set_vec(2, 1, 1,  5, 1, 32'hFFFFFFFF, 32'd0,   32'd0,   32'd0, 4'b0000, 1, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 48'hFFFFFFFF);
    set_vec(3, 4, 3,  1, 0, 32'd0,        32'd5,   32'd3,   32'd9, 4'b0000, 4, 4, 0, 32'd0,   32'd9,   48'd17);
    set_vec(4, 2, 2,  0, 0, 32'd1,        32'd2,   32'd0,   32'd0, 4'b0011, 2, 0, 2, 32'hFFFFFFFF, 32'd0, 48'd0);

    // Reset values
    repeat (3) tick();
    chk("rst tx_req", 64'(tx_req), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst sent", 64'(sent_cnt), 64'd0);
    chk("rst lost", 64'(lost_cnt), 64'd0);
    chk("rst min", 64'(lat_min), 64'(sx(48'hFFFFFFFF)));
    chk("rst max", 64'(lat_max), 64'd0);
    chk("rst sum", 64'(lat_sum), 64'd0);
    reset_n = 1'b1;
    tick();

    // Table-driven runs
    for (int i = 0; i < 5; i++) begin
      s = $sformatf("t%0d", i);
      probe_count = 16'(tab[i].n);
      gap_cycles  = 24'(tab[i].gap);
      start = 1'b1; tick(); start = 1'b0;
      chk({s, " busy"}, 64'(busy), 64'd1);
      chk({s, " tx_req"}, 64'(tx_req), 64'd1);
      d0 = done_seen;
      for (int p = 0; p < tab[i].n; p++) begin
        if (p > 0) begin
          wait_req(s, n);
          if (!tab[i].drop[p-1])
            chk($sformatf("%s gap p%0d", s, p), 64'(n), 64'((tab[i].gap == 0) ? 1 : tab[i].gap));
        end
        do_probe(tab[i].ack, tab[i].rxd, tab[i].lat[p], tab[i].drop[p]);
      end
      wait_done(s);
      tick();
      chk({s, " busy end"}, 64'(busy), 64'd0);
      chk({s, " done pulses"}, 64'(done_seen - d0), 64'd1);
      chk({s, " sent"}, 64'(sent_cnt), 64'(tab[i].e_sent));
      chk({s, " recv"}, 64'(recv_cnt), 64'(tab[i].e_recv));
      chk({s, " lost"}, 64'(lost_cnt), 64'(tab[i].e_lost));
      chk({s, " min"}, 64'(lat_min), 64'(sx(48'(tab[i].e_min))));
      chk({s, " max"}, 64'(lat_max), 64'(sx(48'(tab[i].e_max))));
      chk({s, " sum"}, 64'(lat_sum), 64'(sx(tab[i].e_sum)));
      tick();
    end

    // Timeout fires after exactly TO cycles in WAIT_RX
    probe_count = 16'd1; gap_cycles = 24'd0;
    start = 1'b1; tick(); start = 1'b0;
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    n = 0;
    while (lost_cnt == 16'd0 && n < 100) begin
      tick();
      n++;
    end
    chk("to cycles", 64'(n), 64'(TO));
    chk("to recv", 64'(recv_cnt), 64'd0);
    chk("to done", 64'(done), 64'd1);
    tick();

    // Result on the expiry cycle counts as received
    start = 1'b1; tick(); start = 1'b0;
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    repeat (TO - 1) tick();
    rx_latency = 32'd42; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    chk("exp recv", 64'(recv_cnt), 64'd1);
    chk("exp lost", 64'(lost_cnt), 64'd0);
    chk("exp done", 64'(done), 64'd1);
    chk("exp min", 64'(lat_min), 64'(sx(48'd42)));
    tick();

    // rx_valid and stop in IDLE are ignored
    rx_latency = 32'd7; rx_valid = 1'b1; stop = 1'b1; tick(); rx_valid = 1'b0; stop = 1'b0;
    tick();
    chk("idle recv", 64'(recv_cnt), 64'd1);
    chk("idle busy", 64'(busy), 64'd0);
    chk("idle min", 64'(lat_min), 64'(sx(48'd42)));

    // Continuous run, stop during GAP after the 4th probe
    probe_count = 16'd0; gap_cycles = 24'd8;
    start = 1'b1; tick(); start = 1'b0;
    for (int p = 0; p < 4; p++) begin
      if (p > 0) wait_req("cont", n);
      do_probe(1, 2, 32'(10 * (p + 1)), 1'b0);
    end
    tick(); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    req_seen = 0;
    n = 0;
    while (!done && n < 30) begin
      if (tx_req) req_seen++;
      tick();
      n++;
    end
    chk("cont no 5th req", 64'(req_seen), 64'd0);
    chk("cont done", 64'(done), 64'd1);
    chk("cont sent", 64'(sent_cnt), 64'd4);
    chk("cont recv", 64'(recv_cnt), 64'd4);
    chk("cont sum", 64'(lat_sum), 64'(sx(48'd100)));
    tick();

    // start while busy is ignored, then reset with tx_req pending
    probe_count = 16'd3; gap_cycles = 24'd2;
    start = 1'b1; tick(); start = 1'b0;
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    probe_count = 16'd1; start = 1'b1; tick(); start = 1'b0;
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    rx_latency = 32'd5; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    wait_req("busy start", n);
    chk("busy start sent", 64'(sent_cnt), 64'd1);
    chk("busy start recv", 64'(recv_cnt), 64'd1);
    chk("busy start busy", 64'(busy), 64'd1);
    reset_n = 1'b0; tick();
    chk("mid rst tx_req", 64'(tx_req), 64'd0);
    chk("mid rst busy", 64'(busy), 64'd0);
    chk("mid rst sent", 64'(sent_cnt), 64'd0);
    chk("mid rst recv", 64'(recv_cnt), 64'd0);
    chk("mid rst min", 64'(lat_min), 64'(sx(48'hFFFFFFFF)));
    chk("mid rst sum", 64'(lat_sum), 64'd0);
    reset_n = 1'b1; tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
